line_window_2x2: RTL

Streaming 2×2 neighbourhood extractor for the camera pixel path. It is the reader side of the programmable line-delay buffer: one line of pixels is stored in an internal circular RAM whose length is set at run time, and each incoming pixel is presented together with its left neighbour and the two pixels directly above. It sits between the sensor capture stage and the Bayer-to-RGB conversion, which consumes the registered window.

---
 rtl/line_window_2x2.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/line_window_2x2.sv
// line_window_2x2
//   Streaming 2x2 neighbourhood extractor. One image line is held in a
//   circular RAM whose length is latched at frame_start; every accepted pixel
//   is presented with its left neighbour and the two pixels directly above.
//
// Ports
//   clk, reset_n        pipeline clock, async active-low reset
//   enable              data_in carries a valid pixel this cycle
//   frame_start         synchronous frame restart, latches size
//   data_in [W]         incoming pixel, raster order
//   size [16]           line length, sampled only at frame_start
//   win_tl/win_tr [W]   previous row: column-1, column
//   win_bl/win_br [W]   current row: column-1, column (current pixel)
//   win_valid           one-cycle pulse, window complete
//   col/row [16]        coordinates of win_br
//   err_size            sticky: last latched size was clamped
module line_window_2x2 #(
  parameter int MEMORY_WIDTH = 8,
  parameter int MEMORY_SIZE  = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    frame_start,
  input  logic [MEMORY_WIDTH-1:0] data_in,
  input  logic [15:0]             size,
  output logic [MEMORY_WIDTH-1:0] win_tl,
  output logic [MEMORY_WIDTH-1:0] win_tr,
  output logic [MEMORY_WIDTH-1:0] win_bl,
  output logic [MEMORY_WIDTH-1:0] win_br,
  output logic                    win_valid,
  output logic [15:0]             col,
  output logic [15:0]             row,
  output logic                    err_size
);

  localparam int AW = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;

  logic [MEMORY_WIDTH-1:0] ram [MEMORY_SIZE];

  logic [AW-1:0]           ptr_q, ptr_d, waddr;
  logic [15:0]             size_l_q, size_l_d;
  logic                    err_q, err_d;
  logic [MEMORY_WIDTH-1:0] d1_q, q1_q;
  logic                    s1_valid_q;
  logic [15:0]             cnt_col_q, cnt_row_q;
  logic [MEMORY_WIDTH-1:0] tl_q, tr_q, bl_q, br_q;
  logic                    win_valid_q;
  logic [15:0]             col_q, row_q;
  logic                    ptr_last, col_last, stage2;

  assign win_tl    = tl_q;
  assign win_tr    = tr_q;
  assign win_bl    = bl_q;
  assign win_br    = br_q;
  assign win_valid = win_valid_q;
  assign col       = col_q;
  assign row       = row_q;
  assign err_size  = err_q;

  // A restart discards whatever is pending in stage 1, so stage 2 is gated.
  assign stage2   = s1_valid_q && !frame_start;
  assign ptr_last = (16'(ptr_q) == size_l_q - 16'd1);
  assign col_last = (cnt_col_q == size_l_q - 16'd1);

  always_comb begin
    // A pixel arriving with frame_start is column 0 of the new frame.
    waddr = frame_start ? '0 : ptr_q;

    if (size < 16'd2) begin
      size_l_d = 16'd2;
      err_d    = 1'b1;
    end else if ({1'b0, size} > 17'(MEMORY_SIZE)) begin
      size_l_d = 16'(MEMORY_SIZE);
      err_d    = 1'b1;
    end else begin
      size_l_d = size;
      err_d    = 1'b0;
    end

    if (frame_start)
      ptr_d = enable ? AW'(1) : '0;
    else if (enable)
      ptr_d = ptr_last ? '0 : ptr_q + AW'(1);
    else
      ptr_d = ptr_q;
  end

  // Line RAM: read-before-write, so q1 holds the pixel one line above.
  always_ff @(posedge clk) begin
    if (enable) begin
      q1_q        <= ram[waddr];
      ram[waddr]  <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      size_l_q    <= 16'(MEMORY_SIZE);
      err_q       <= 1'b0;
      d1_q        <= '0;
      s1_valid_q  <= 1'b0;
      cnt_col_q   <= '0;
      cnt_row_q   <= '0;
      tl_q        <= '0;
      tr_q        <= '0;
      bl_q        <= '0;
      br_q        <= '0;
      win_valid_q <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= enable;
      win_valid_q <= 1'b0;
      if (enable)
        d1_q <= data_in;

      if (frame_start) begin
        size_l_q  <= size_l_d;
        err_q     <= err_d;
        cnt_col_q <= '0;
        cnt_row_q <= '0;
      end else if (stage2) begin
        bl_q        <= br_q;
        tl_q        <= tr_q;
        br_q        <= d1_q;
        tr_q        <= q1_q;
        col_q       <= cnt_col_q;
        row_q       <= cnt_row_q;
        // Column 0 still carries the previous row's last pixel on the left,
        // and row 0 reads stale RAM above: neither is a real window.
        win_valid_q <= (cnt_col_q != 16'd0) && (cnt_row_q != 16'd0);
        if (col_last) begin
          cnt_col_q <= '0;
          if (cnt_row_q != 16'hFFFF)
            cnt_row_q <= cnt_row_q + 16'd1;
        end else begin
          cnt_col_q <= cnt_col_q + 16'd1;
        end
      end
    end
  end

endmodule
